// File: rtl/dmem_ctrl.sv
// Data-memory controller between the CPU load/store unit and a word-wide RAM.
// It accepts one request at a time over a valid/ready handshake and applies
// WAIT_CYCLES extra access cycles before touching the array. Misaligned,
// out-of-range and illegal-op requests are answered with rsp_err and have no
// side effect on memory.
module dmem_ctrl #(
  parameter int          DEPTH_LOG2  = 15,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN      = 33'd4 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic [31:0] mem [DEPTH];

  logic [2:0]  op_p0;
  logic        we_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;

  logic                  accept;
  logic                  illegal;
  logic                  array_op;
  logic                  rsp_done;
  logic [31:0]           off_p0;
  logic [DEPTH_LOG2-1:0] idx_p0;
  logic [3:0]            mask_p0;
  logic [31:0]           lanes_p0;
  logic                  unused_off;

  // Legality of a request; the decision is made in the accepting cycle so an
  // illegal request goes straight to the response state.
  function automatic logic req_illegal(input logic we, input logic [2:0] op,
                                       input logic [31:0] addr);
    logic [31:0] off;
    logic        bad;
    off = addr - BASE_ADDR;
    bad = (op == 3'b011) || (op == 3'b100) || (op == 3'b111);
    bad = bad || (we && op[2]);
    bad = bad || ((op[1:0] == 2'b10) && addr[0]);
    bad = bad || ((op == 3'b000) && (addr[1:0] != 2'b00));
    bad = bad || (addr < BASE_ADDR);
    bad = bad || ({1'b0, off} >= SPAN);
    return bad;
  endfunction

  // Byte-enable mask for a store of the given width at the given lane.
  function automatic logic [3:0] store_mask(input logic [2:0] op, input logic [1:0] lane);
    case (op[1:0])
      2'b01:   return 4'b0001 << lane;
      2'b10:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the mask alone picks the target bytes.
  function automatic logic [31:0] store_lanes(input logic [2:0] op, input logic [31:0] wdata);
    case (op[1:0])
      2'b01:   return {4{wdata[7:0]}};
      2'b10:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Lane select and sign/zero extension of a loaded word; op[2] marks unsigned.
  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic        [31:0] shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    shifted = word >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = lane[1] ? word[31:16] : word[15:0];
    case (op[1:0])
      2'b01: begin
        ext = b;
        return op[2] ? {24'b0, b} : ext;
      end
      2'b10: begin
        ext = h;
        return op[2] ? {16'b0, h} : ext;
      end
      default: return word;
    endcase
  endfunction

  assign accept     = req_valid && (state == IDLE);
  assign illegal    = req_illegal(req_we, req_op, req_addr);
  assign array_op   = (state == ACCESS) && (wait_cnt == 4'd0);
  assign rsp_done   = (state == RESP) && rsp_ready;
  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == RESP);

  assign off_p0     = addr_p0 - BASE_ADDR;
  assign idx_p0     = off_p0[DEPTH_LOG2+1:2];
  assign mask_p0    = store_mask(op_p0, addr_p0[1:0]);
  assign lanes_p0   = store_lanes(op_p0, wdata_p0);
  assign unused_off = ^{off_p0[31:DEPTH_LOG2+2], off_p0[1:0]};

  // Next-state decode: accept -> ACCESS or RESP, ACCESS drains the wait count.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = illegal ? RESP : ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        wait_cnt  <= WAIT_INIT;
        rsp_err   <= illegal;
        rsp_rdata <= 32'd0;
      end else if ((state == ACCESS) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (array_op && !we_p0) begin
        rsp_rdata <= load_extract(op_p0, addr_p0[1:0], mem[idx_p0]);
      end
      if (rsp_done) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end

  // ---- stage p0: request capture at the accepting edge ----
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0    <= req_op;
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  // Masked array write at the end of the last ACCESS cycle; reset suppresses it.
  always_ff @(posedge clk) begin
    if (array_op && we_p0 && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_p0[i]) mem[idx_p0][8*i +: 8] <= lanes_p0[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (default depth, base 0, one wait cycle).
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_B  = 3'b001;
  localparam logic [2:0] OP_H  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b101;
  localparam logic [2:0] OP_HU = 3'b110;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .DEPTH_LOG2 (15),
    .BASE_ADDR  (32'h0),
    .WAIT_CYCLES(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request starting at a negedge with the controller idle; returns
  // latency (negedges after the handshake edge until rsp_valid), data and error.
  task automatic send(input string tag, input logic we, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wd);
    int n;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b1;
    req_op    = 3'b000;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'hFFFF_FFFF;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    r_lat  = n;
    r_data = rsp_rdata;
    r_err  = rsp_err;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic xfer(input string tag, input logic we, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    send(tag, we, op, addr, wd);
    chk({tag, "_data"}, r_data, exp_data);
    chk({tag, "_err"}, 32'(r_err), 32'(exp_err));
    chk({tag, "_lat"}, 32'(r_lat), 32'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_op    = 3'b000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Word store/load and sub-word lanes
    xfer("sw100", 1'b1, OP_W, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 3);
    xfer("lw100", 1'b0, OP_W, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    xfer("sw104", 1'b1, OP_W, 32'h104, 32'h0, 32'h0, 1'b0, 3);
    xfer("sb107", 1'b1, OP_B, 32'h107, 32'h80, 32'h0, 1'b0, 3);
    xfer("lw104a", 1'b0, OP_W, 32'h104, 32'h0, 32'h80000000, 1'b0, 3);
    xfer("lb107", 1'b0, OP_B, 32'h107, 32'h0, 32'hFFFFFF80, 1'b0, 3);
    xfer("lbu107", 1'b0, OP_BU, 32'h107, 32'h0, 32'h00000080, 1'b0, 3);
    xfer("sh104", 1'b1, OP_H, 32'h104, 32'h1234, 32'h0, 1'b0, 3);
    xfer("lw104b", 1'b0, OP_W, 32'h104, 32'h0, 32'h80001234, 1'b0, 3);
    xfer("lh106", 1'b0, OP_H, 32'h106, 32'h0, 32'hFFFF8000, 1'b0, 3);
    xfer("lhu106", 1'b0, OP_HU, 32'h106, 32'h0, 32'h00008000, 1'b0, 3);

    // Misaligned and illegal-op requests
    xfer("lh101", 1'b0, OP_H, 32'h101, 32'h0, 32'h0, 1'b1, 1);
    xfer("sw102", 1'b1, OP_W, 32'h102, 32'hCAFEF00D, 32'h0, 1'b1, 1);
    xfer("op011", 1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1);
    xfer("st_bu", 1'b1, OP_BU, 32'h100, 32'h0, 32'h0, 1'b1, 1);
    xfer("lw100b", 1'b0, OP_W, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3);

    // Range boundaries
    xfer("sw0", 1'b1, OP_W, 32'h0, 32'h11111111, 32'h0, 1'b0, 3);
    xfer("sw_oor", 1'b1, OP_W, 32'h20000, 32'hBAD0BAD0, 32'h0, 1'b1, 1);
    xfer("lw_oor", 1'b0, OP_W, 32'h20000, 32'h0, 32'h0, 1'b1, 1);
    xfer("lw_top", 1'b0, OP_W, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 1);
    xfer("lw0", 1'b0, OP_W, 32'h0, 32'h0, 32'h11111111, 1'b0, 3);
    xfer("sw_last", 1'b1, OP_W, 32'h1FFFC, 32'hA5A5A5A5, 32'h0, 1'b0, 3);
    xfer("lw_last", 1'b0, OP_W, 32'h1FFFC, 32'h0, 32'hA5A5A5A5, 1'b0, 3);

    // Response back-pressure
    rsp_ready = 1'b0;
    chk("hold_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_op    = OP_W;
    req_addr  = 32'h100;
    req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("hold_err", 32'(rsp_err), 32'd0);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_valid", 32'(rsp_valid), 32'd0);
    chk("release_ready", 32'(req_ready), 32'd1);
    xfer("b2b", 1'b0, OP_W, 32'h104, 32'h0, 32'h80001234, 1'b0, 3);

    // Reset during the first ACCESS cycle of a store
    xfer("sw200", 1'b1, OP_W, 32'h200, 32'h11, 32'h0, 1'b0, 3);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_op    = OP_W;
    req_addr  = 32'h200;
    req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'd0);
    chk("abort_rsp_err", 32'(rsp_err), 32'd0);
    chk("abort_busy_low", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    xfer("lw200", 1'b0, OP_W, 32'h200, 32'h0, 32'h11, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
